// File: rtl/edge_detect_pkg.sv
// -----------------------------------------------------------------------------
// edge_detect_pkg
//   Shared types and constants for the multi-channel edge detector.
//   - edge_state_t : per-channel Moore FSM state encoding
//   - MODE_*       : per-channel edge-select codes (bit0 = rise, bit1 = fall)
//   - edge_next    : FSM next-state function, shared so the transition table
//                    lives in exactly one place
// -----------------------------------------------------------------------------
package edge_detect_pkg;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        RISE = 2'd1,
        ONE  = 2'd2,
        FALL = 2'd3
    } edge_state_t;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    // RISE and FALL are transient: they always leave after one cycle, so a
    // filtered level that flips every cycle alternates RISE/FALL directly.
    function automatic edge_state_t edge_next(input edge_state_t state,
                                              input logic        filt);
        edge_state_t nxt;
        case (state)
            ZERO:    nxt = filt ? RISE : ZERO;
            RISE:    nxt = filt ? ONE  : FALL;
            ONE:     nxt = filt ? ONE  : FALL;
            FALL:    nxt = filt ? RISE : ZERO;
            default: nxt = ZERO;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/edge_detect_channel.sv
// -----------------------------------------------------------------------------
// edge_detect_channel
//   One channel of the edge detector: synchroniser chain, stability filter,
//   Moore edge FSM, registered mode and sticky pending flag.
// Ports
//   clk        in  clock, all state on posedge
//   reset_n    in  asynchronous active-low reset
//   level      in  raw asynchronous level
//   mode       in  [1:0] edge select: bit0 rise, bit1 fall
//   clr        in  pending clear pulse
//   rise_tick  out one-cycle rising-edge tick (unmasked)
//   fall_tick  out one-cycle falling-edge tick (unmasked)
//   tick       out mode-masked tick
//   level_filt out debounced level
//   pending    out sticky masked-edge flag
// -----------------------------------------------------------------------------
module edge_detect_channel
    import edge_detect_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       level,
    input  logic [1:0] mode,
    input  logic       clr,
    output logic       rise_tick,
    output logic       fall_tick,
    output logic       tick,
    output logic       level_filt,
    output logic       pending
);

    localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   filt_reg,    filt_next;
    logic [CNT_W-1:0]       cnt_reg,     cnt_next;
    edge_state_t            state_reg,   state_next;
    logic [1:0]             mode_reg;
    logic                   pending_reg, pending_next;
    logic                   sync_s;

    assign sync_s = sync_reg[SYNC_STAGES-1];

    // Filter: the synced level must disagree with the accepted level for
    // FILTER_CYCLES consecutive cycles before it is taken; any agreement in
    // between restarts the count, so short glitches never reach the FSM.
    always_comb begin
        filt_next = filt_reg;
        cnt_next  = cnt_reg;
        if (sync_s == filt_reg) begin
            cnt_next = '0;
        end else if (cnt_reg == CNT_LAST) begin
            filt_next = sync_s;
            cnt_next  = '0;
        end else begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_comb begin
        state_next = edge_next(state_reg, filt_reg);
    end

    // Outputs decode registered state only.
    assign rise_tick  = (state_reg == RISE);
    assign fall_tick  = (state_reg == FALL);
    assign tick       = (rise_tick & mode_reg[0]) | (fall_tick & mode_reg[1]);
    assign level_filt = filt_reg;
    assign pending    = pending_reg;

    // A new tick beats a simultaneous clear so no event is lost.
    always_comb begin
        pending_next = tick | (pending_reg & ~clr);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg    <= '0;
            filt_reg    <= 1'b0;
            cnt_reg     <= '0;
            state_reg   <= ZERO;
            mode_reg    <= MODE_OFF;
            pending_reg <= 1'b0;
        end else begin
            sync_reg    <= {sync_reg[SYNC_STAGES-2:0], level};
            filt_reg    <= filt_next;
            cnt_reg     <= cnt_next;
            state_reg   <= state_next;
            mode_reg    <= mode;
            pending_reg <= pending_next;
        end
    end

endmodule

// File: rtl/multi_edge_detect.sv
// -----------------------------------------------------------------------------
// multi_edge_detect
//   N_CH independent edge-detector channels plus an interrupt summary.
// Ports
//   clk        in  clock
//   reset_n    in  asynchronous active-low reset
//   level      in  [N_CH-1:0]   raw asynchronous levels
//   mode       in  [2*N_CH-1:0] per channel [2i+1:2i]: 00 off 01 rise 10 fall 11 both
//   clr        in  [N_CH-1:0]   per-channel pending clear
//   rise_tick  out [N_CH-1:0]   unmasked rising ticks
//   fall_tick  out [N_CH-1:0]   unmasked falling ticks
//   tick       out [N_CH-1:0]   mode-masked ticks
//   level_filt out [N_CH-1:0]   debounced levels
//   pending    out [N_CH-1:0]   sticky masked-edge flags
//   irq        out              OR of pending
// -----------------------------------------------------------------------------
module multi_edge_detect
    import edge_detect_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_CH-1:0]   level,
    input  logic [2*N_CH-1:0] mode,
    input  logic [N_CH-1:0]   clr,
    output logic [N_CH-1:0]   rise_tick,
    output logic [N_CH-1:0]   fall_tick,
    output logic [N_CH-1:0]   tick,
    output logic [N_CH-1:0]   level_filt,
    output logic [N_CH-1:0]   pending,
    output logic              irq
);

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            edge_detect_channel #(
                .SYNC_STAGES  (SYNC_STAGES),
                .FILTER_CYCLES(FILTER_CYCLES)
            ) u_ch (
                .clk       (clk),
                .reset_n   (reset_n),
                .level     (level[gi]),
                .mode      (mode[2*gi +: 2]),
                .clr       (clr[gi]),
                .rise_tick (rise_tick[gi]),
                .fall_tick (fall_tick[gi]),
                .tick      (tick[gi]),
                .level_filt(level_filt[gi]),
                .pending   (pending[gi])
            );
        end
    endgenerate

    // Pending bits are flops, so irq is a pure reduction with no extra stage.
    assign irq = |pending;

endmodule
